// File: rtl/div_error_accumulator.sv
// Error-metric stage for the array dividers: accumulates quotient SSE, max |quotient error|
// and mismatch count over a window of (approximate, exact) quotient/remainder pairs.
module div_error_accumulator #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q_apx,
    input  logic [W-1:0]     r_apx,
    input  logic [W-1:0]     q_exact,
    input  logic [W-1:0]     r_exact,
    output logic [ACC_W-1:0] sse_q,
    output logic             sse_ovf,
    output logic [W-1:0]     max_err_q,
    output logic [CNT_W-1:0] mism_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);
    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, num_reg;
    logic             v1, mism1;
    logic [W-1:0]     e1, diff;
    logic             accept, last_accept, start_ok;
    logic [2*W-1:0]   sq;
    logic [ACC_W:0]   sum;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign state_dbg   = state;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt == num_reg - CNT_ONE);
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign diff        = (q_apx >= q_exact) ? (q_apx - q_exact) : (q_exact - q_apx);
    assign sq          = e1 * e1;
    // One extra bit catches the carry out of the accumulator for saturation.
    assign sum         = {1'b0, sse_q} + {{(ACC_W+1-2*W){1'b0}}, sq};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = (num_samples == '0) ? DONE : RUN;
            RUN:        if (last_accept) state_nx = DRAIN;
            DRAIN:      if (!v1) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; num_reg <= '0; v1 <= 1'b0; e1 <= '0; mism1 <= 1'b0;
            sse_q <= '0; sse_ovf <= 1'b0; max_err_q <= '0; mism_cnt <= '0;
        end else if (clear) begin
            cnt <= '0; num_reg <= '0; v1 <= 1'b0; e1 <= '0; mism1 <= 1'b0;
            sse_q <= '0; sse_ovf <= 1'b0; max_err_q <= '0; mism_cnt <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                e1    <= diff;
                mism1 <= (q_apx != q_exact) || (r_apx != r_exact);
            end
            if (start_ok) begin
                num_reg   <= num_samples;
                cnt       <= '0;
                sse_q     <= '0;
                sse_ovf   <= 1'b0;
                max_err_q <= '0;
                mism_cnt  <= '0;
            end else begin
                if (accept) cnt <= cnt + CNT_ONE;
                if (v1) begin
                    if (sum[ACC_W]) begin
                        sse_q   <= '1;
                        sse_ovf <= 1'b1;
                    end else begin
                        sse_q <= sum[ACC_W-1:0];
                    end
                    if (e1 > max_err_q) max_err_q <= e1;
                    if (mism1) mism_cnt <= mism_cnt + CNT_ONE;
                end
            end
        end
    end
endmodule
